axi_arbiter_r: RTL and testbench

- Read-channel arbiter for the 4-master / 8-slave AXI4 interconnect.
- Sits directly upstream of the read-channel master mux and drives its one-hot grant inputs m0_rgrnt..m3_rgrnt.
- Grants one master at a time and holds the grant until that master's read burst completes (AR handshake, then ARLEN+1 R beats).
- Priority rotates past the previous bus owner (round-robin).

---
 rtl/axi_rd_arb_pkg.sv | 17 +
 rtl/rr_pick4.sv | 29 ++
 rtl/axi_arbiter_r.sv | 114 +++++++++++
 tb/tb_axi_arbiter_r.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared types for the AXI read-channel arbiter: FSM states, grant vector
// and a one-hot to index encoder.
package axi_rd_arb_pkg;
    localparam int MST_NUM = 4;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} rarb_state_t;
    typedef logic [MST_NUM-1:0] grant_t;

    function automatic logic [1:0] oh2idx(input grant_t g);
        logic [1:0] idx;
        idx = 2'd0;
        if (g[1]) idx = 2'd1;
        if (g[2]) idx = 2'd2;
        if (g[3]) idx = 2'd3;
        return idx;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way picker: round-robin after last_owner, or fixed
// priority (lowest index) when rr_en is low. Output is one-hot or zero.
module rr_pick4
    import axi_rd_arb_pkg::*;
(
    input  grant_t     req,
    input  logic [1:0] last_owner,
    input  logic       rr_en,
    output grant_t     win
);
    logic [1:0] idx;

    always_comb begin
        win = '0;
        idx = 2'd0;
        if (rr_en) begin
            // walk from lowest priority (last_owner itself) up so the nearest
            // requester after last_owner overwrites the rest
            for (int k = 4; k >= 1; k--) begin
                idx = last_owner + 2'(k);
                if (req[idx]) win = grant_t'(1) << idx;
            end
        end else begin
            for (int k = MST_NUM - 1; k >= 0; k--) begin
                if (req[k]) win = grant_t'(1) << k;
            end
        end
    end
endmodule

// File: rtl/axi_arbiter_r.sv
// Read-channel arbiter: grants one master per burst and holds the grant
// through the AR handshake and ARLEN+1 R beats. All outputs are registered.
module axi_arbiter_r
    import axi_rd_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       m0_ARVALID,
    input  logic       m1_ARVALID,
    input  logic       m2_ARVALID,
    input  logic       m3_ARVALID,
    input  logic [7:0] m0_ARLEN,
    input  logic [7:0] m1_ARLEN,
    input  logic [7:0] m2_ARLEN,
    input  logic [7:0] m3_ARLEN,
    input  logic       s_ARVALID,
    input  logic       m_ARREADY,
    input  logic       m_RVALID,
    input  logic       s_RREADY,
    input  logic       m_RLAST,
    output logic       m0_rgrnt,
    output logic       m1_rgrnt,
    output logic       m2_rgrnt,
    output logic       m3_rgrnt,
    output logic       rbusy,
    output logic       rlast_err
);
    rarb_state_t state, state_nxt;
    grant_t      grant_q, grant_nxt, pick;
    logic [7:0]  beat_cnt, beat_nxt, arlen_sel;
    logic [1:0]  last_owner, owner_nxt;
    logic        busy_q, busy_nxt, err_q, err_nxt;
    grant_t      req;
    logic        beat;

    assign req  = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
    assign beat = s_RREADY & m_RVALID;

    always_comb begin
        arlen_sel = ({8{grant_q[0]}} & m0_ARLEN) | ({8{grant_q[1]}} & m1_ARLEN)
                  | ({8{grant_q[2]}} & m2_ARLEN) | ({8{grant_q[3]}} & m3_ARLEN);
    end

    rr_pick4 u_pick (
        .req        (req),
        .last_owner (last_owner),
        .rr_en      (RR_EN),
        .win        (pick)
    );

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        beat_nxt  = beat_cnt;
        owner_nxt = last_owner;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = pick;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (s_ARVALID && m_ARREADY) begin
                    beat_nxt  = arlen_sel;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    // the counter decides release; RLAST is only cross-checked
                    err_nxt = m_RLAST != (beat_cnt == 8'd0);
                    if (beat_cnt == 8'd0) begin
                        grant_nxt = '0;
                        owner_nxt = oh2idx(grant_q);
                        state_nxt = IDLE;
                    end else begin
                        beat_nxt = beat_cnt - 8'd1;
                    end
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = state_nxt != IDLE;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            grant_q    <= '0;
            beat_cnt   <= 8'd0;
            last_owner <= 2'd3;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_q    <= grant_nxt;
            beat_cnt   <= beat_nxt;
            last_owner <= owner_nxt;
            busy_q     <= busy_nxt;
            err_q      <= err_nxt;
        end
    end

    assign {m3_rgrnt, m2_rgrnt, m1_rgrnt, m0_rgrnt} = grant_q;
    assign rbusy     = busy_q;
    assign rlast_err = err_q;
endmodule

// File: tb/tb_axi_arbiter_r.sv
// Directed bench for axi_arbiter_r; a second instance runs fixed priority.
module tb_axi_arbiter_r;
    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic [3:0] arv;
    logic [7:0] arlen [4];
    logic       s_arv, ar_rdy, rvalid, rready, rlast;
    wire  [3:0] g0, g1;
    wire        busy0, err0, busy1, err1;
    int         checks = 0;
    int         errors = 0;

    always #5 ACLK = ~ACLK;

    axi_arbiter_r #(.RR_EN(1'b1)) u_rr (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m0_ARVALID(arv[0]), .m1_ARVALID(arv[1]), .m2_ARVALID(arv[2]), .m3_ARVALID(arv[3]),
        .m0_ARLEN(arlen[0]), .m1_ARLEN(arlen[1]), .m2_ARLEN(arlen[2]), .m3_ARLEN(arlen[3]),
        .s_ARVALID(s_arv), .m_ARREADY(ar_rdy), .m_RVALID(rvalid), .s_RREADY(rready),
        .m_RLAST(rlast),
        .m0_rgrnt(g0[0]), .m1_rgrnt(g0[1]), .m2_rgrnt(g0[2]), .m3_rgrnt(g0[3]),
        .rbusy(busy0), .rlast_err(err0)
    );

    axi_arbiter_r #(.RR_EN(1'b0)) u_fix (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m0_ARVALID(arv[0]), .m1_ARVALID(arv[1]), .m2_ARVALID(arv[2]), .m3_ARVALID(arv[3]),
        .m0_ARLEN(arlen[0]), .m1_ARLEN(arlen[1]), .m2_ARLEN(arlen[2]), .m3_ARLEN(arlen[3]),
        .s_ARVALID(s_arv), .m_ARREADY(ar_rdy), .m_RVALID(rvalid), .s_RREADY(rready),
        .m_RLAST(rlast),
        .m0_rgrnt(g1[0]), .m1_rgrnt(g1[1]), .m2_rgrnt(g1[2]), .m3_rgrnt(g1[3]),
        .rbusy(busy1), .rlast_err(err1)
    );

    always @(negedge ACLK) begin
        assert ($onehot0(g0) && $onehot0(g1))
        else $error("FAIL onehot g0=%b g1=%b", g0, g1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic idle_inputs();
        arv = 4'b0;
        for (int i = 0; i < 4; i++) arlen[i] = 8'd0;
        s_arv = 1'b0; ar_rdy = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        idle_inputs();
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic ar_hs();
        s_arv = 1'b1; ar_rdy = 1'b1;
        tick();
        s_arv = 1'b0; ar_rdy = 1'b0; arv = 4'b0;
    endtask

    initial begin
        int nb;
        ARESETn = 1'b0;
        idle_inputs();
        @(negedge ACLK);
        @(negedge ACLK);
        chk("rst_grant", 32'(g0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_err", 32'(err0), 32'h0);
        ARESETn = 1'b1;

        // basic burst, m2 ARLEN=3, with an ADDR stall first
        arv = 4'b0100; arlen[2] = 8'd3;
        tick();
        chk("t1_grant", 32'(g0), 32'h4);
        chk("t1_busy", 32'(busy0), 32'h1);
        tick();
        chk("t1_addr_hold", 32'(g0), 32'h4);
        ar_hs();
        rvalid = 1'b1; rready = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            rlast = (b == 4);
            tick();
            chk("t1_beat_grant", 32'(g0), (b < 4) ? 32'h4 : 32'h0);
            chk("t1_beat_busy", 32'(busy0), (b < 4) ? 32'h1 : 32'h0);
            chk("t1_beat_err", 32'(err0), 32'h0);
        end

        // all four requesting, single-beat bursts: RR vs fixed priority
        do_reset();
        arv = 4'hf;
        s_arv = 1'b1; ar_rdy = 1'b1; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_rr_grant", 32'(g0), 32'(1) << (k % 4));
            chk("t2_fix_grant", 32'(g1), 32'h1);
            tick();
            chk("t2_rr_hold", 32'(g0), 32'(1) << (k % 4));
            chk("t2_fix_err", 32'(err1), 32'h0);
            tick();
            chk("t2_rr_dead", 32'(g0), 32'h0);
            chk("t2_fix_dead", 32'(g1), 32'h0);
            chk("t2_fix_busy", 32'(busy1), 32'h0);
        end

        // ARLEN=7 with RVALID every other cycle
        do_reset();
        arv = 4'b0010; arlen[1] = 8'd7;
        tick();
        chk("t3_grant", 32'(g0), 32'h2);
        ar_hs();
        rready = 1'b1;
        nb = 0;
        for (int i = 0; i < 15; i++) begin
            rvalid = (i % 2 == 0);
            rlast  = rvalid && (nb == 7);
            tick();
            if (rvalid) nb++;
            chk("t3_grant_run", 32'(g0), (nb < 8) ? 32'h2 : 32'h0);
            chk("t3_err", 32'(err0), 32'h0);
        end
        rvalid = 1'b0; rlast = 1'b0;

        // early RLAST on beat 2
        do_reset();
        arv = 4'b1000; arlen[3] = 8'd3;
        tick();
        chk("t4_grant", 32'(g0), 32'h8);
        ar_hs();
        rvalid = 1'b1; rready = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            rlast = (b == 2) || (b == 4);
            tick();
            chk("t4_err", 32'(err0), (b == 2) ? 32'h1 : 32'h0);
            chk("t4_grant_run", 32'(g0), (b < 4) ? 32'h8 : 32'h0);
        end
        rvalid = 1'b0; rlast = 1'b0;

        // finish an m1 burst, then reset mid-burst of m2
        do_reset();
        arv = 4'b0010;
        tick();
        ar_hs();
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        tick();
        chk("t5_m1_done", 32'(g0), 32'h0);
        rvalid = 1'b0;
        arv = 4'b0100; arlen[2] = 8'd3;
        tick();
        chk("t5_m2_grant", 32'(g0), 32'h4);
        ar_hs();
        rvalid = 1'b1; rlast = 1'b1;
        tick();
        chk("t5_err_beat1", 32'(err0), 32'h1);
        rlast = 1'b0;
        #2 ARESETn = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(g0), 32'h0);
        chk("t5_rst_busy", 32'(busy0), 32'h0);
        chk("t5_rst_err", 32'(err0), 32'h0);
        rvalid = 1'b0;
        arv = 4'b1010;
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        chk("t5_post_rst", 32'(g0), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
